// File: rtl/mult_result_fifo.sv
// mult_result_fifo: output stage of the 32x32 shift-add multiplier.
//
// Function:
//   - Captures each finished magnitude product and applies the sign tag
//     (full 64-bit two's complement negate).
//   - Pushes the corrected result into a DEPTH-entry FIFO.
//   - Returns a one-cycle ack that releases the multiplier from DONE.
//   - Presents the head entry as a HI/LO valid/ready stream.
//
// Handshake (out_valid/out_ready):
//   - An entry transfers on a rising clk edge where out_valid && out_ready.
//   - out_valid depends only on registered state. It never looks at
//     out_ready, and it stays high until the transfer.
//   - out_hi/out_lo hold steady while out_valid is high and no transfer
//     has happened.
//   - out_ready while out_valid is low has no effect.
//
// Build option:
//   - MULT_OVF_FLAG_EN adds ovf_out.
//   - ovf_out is a per-entry flag, set when the corrected result does not
//     fit a signed 32-bit value.
//
// Debug:
//   - dbg_state exposes the capture FSM state for checkers.
module mult_result_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          done_in,
  input  logic [63:0]   product_in,
  input  logic          neg_in,
  output logic          ack_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_hi,
  output logic [31:0]   out_lo,
`ifdef MULT_OVF_FLAG_EN
  output logic          ovf_out,
`endif
  output logic [AW:0]   count,
  output logic [1:0]    dbg_state
);

`ifdef MULT_OVF_FLAG_EN
  localparam int DW = 65;
`else
  localparam int DW = 64;
`endif

  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACK     = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_ack;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [DW-1:0]   r_mem [DEPTH];
  logic [DW-1:0]   r_head;

  logic [63:0]     w_corr;
  logic [DW-1:0]   w_entry;
  logic            w_push;
  logic            w_pop;
  logic [AW-1:0]   w_rd_next;

  // Sign correction of the incoming magnitude.
  assign w_corr = neg_in ? (~product_in + 64'd1) : product_in;

`ifdef MULT_OVF_FLAG_EN
  // Bits [63:31] all equal means the value fits a signed 32-bit word.
  logic w_ovf;
  assign w_ovf   = ~((&w_corr[63:31]) | ~(|w_corr[63:31]));
  assign w_entry = {w_ovf, w_corr};
`else
  assign w_entry = w_corr;
`endif

  // Full is judged on the count before the edge.
  // A pop in the same cycle does not free space for this push; the FSM
  // stays in IDLE and retries on the next edge.
  assign w_push    = (r_state == S_IDLE) && done_in && (r_count != C_FULL);
  assign w_pop     = (r_count != '0) && out_ready;
  assign w_rd_next = r_rd_ptr + AW'(1);

  // Capture FSM.
  // ack is registered, so it is high exactly for the ACK cycle.
  // RELEASE waits for done_in to fall, which prevents a double capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_push) begin
            r_state <= S_ACK;
            r_ack   <= 1'b1;
          end
        end
        S_ACK: begin
          r_state <= S_RELEASE;
          r_ack   <= 1'b0;
        end
        S_RELEASE: begin
          if (!done_in) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH = 2**AW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_next;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered head word.
  // It changes only when the head advances (pop) or when the first entry
  // lands in an empty FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
    end else if (w_pop) begin
      if (r_count == C_ONE) begin
        if (w_push) r_head <= w_entry;
      end else begin
        r_head <= r_mem[w_rd_next];
      end
    end else if (w_push && (r_count == '0)) begin
      r_head <= w_entry;
    end
  end

  assign ack_out   = r_ack;
  assign out_valid = (r_count != '0);
  assign out_hi    = r_head[63:32];
  assign out_lo    = r_head[31:0];
  assign count     = r_count;
  assign dbg_state = r_state;
`ifdef MULT_OVF_FLAG_EN
  assign ovf_out   = r_head[64];
`endif

endmodule

// File: tb/tb_mult_result_fifo.sv
// Testbench for mult_result_fifo (DEPTH=4): vector table, corner-case
// sequences, and randomized traffic checked against a queue model.
`timescale 1ns/1ps
module tb_mult_result_fifo;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int W     = 65;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          done_in = 1'b0;
  logic [63:0]   product_in = '0;
  logic          neg_in = 1'b0;
  logic          ack_out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_hi;
  logic [31:0]   out_lo;
  logic [AW:0]   count;
  logic [1:0]    dbg_state;
`ifdef MULT_OVF_FLAG_EN
  logic          ovf_out;
`endif

  mult_result_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .done_in    (done_in),
    .product_in (product_in),
    .neg_in     (neg_in),
    .ack_out    (ack_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_hi     (out_hi),
    .out_lo     (out_lo),
`ifdef MULT_OVF_FLAG_EN
    .ovf_out    (ovf_out),
`endif
    .count      (count),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] idle_code;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: signed result from plain arithmetic, range test on the value.
  function automatic logic [W-1:0] model_entry(input logic [63:0] p, input logic n);
    logic [63:0] v;
    logic signed [63:0] s;
    logic o;
    v = n ? (64'd0 - p) : p;
    s = v;
    o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {o, v};
  endfunction

  // Monitor: mid-cycle compare of occupancy/head against the model, consume on transfer.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        check("mon_count", 64'(count), 64'(exp_q.size()));
        check("mon_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          check("mon_head", {out_hi, out_lo}, exp_q[0][63:0]);
`ifdef MULT_OVF_FLAG_EN
          check("mon_ovf", 64'(ovf_out), 64'(exp_q[0][64]));
`endif
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present one product, wait for its ack, then release done_in and let the FSM return to IDLE.
  task automatic push_product(input logic [63:0] p, input logic n);
    int waited;
    bit got;
    waited = 0;
    got = 0;
    @(negedge clk);
    done_in = 1'b1; product_in = p; neg_in = n;
    while (!got && waited < 300) begin
      @(posedge clk); #1;
      waited++;
      if (ack_out) got = 1;
    end
    if (!got) begin
      check("ack_timeout", 64'd0, 64'd1);
      @(negedge clk);
      done_in = 1'b0;
    end else begin
      exp_q.push_back(model_entry(p, n));
      @(negedge clk);
      done_in = 1'b0;
      @(posedge clk); #1;
      check("ack_one_cycle", 64'(ack_out), 64'd0);
      @(posedge clk);
    end
  endtask

  task automatic pop_one();
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic drain_all(input string name);
    int waited;
    waited = 0;
    @(negedge clk); out_ready = 1'b1;
    while (exp_q.size() != 0 && waited < 100) begin
      @(negedge clk); waited++;
    end
    out_ready = 1'b0;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [63:0] prod;
    logic        neg;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra_acks;
    bit rand_done;

    vecs[0] = '{64'h0000_0000_0000_0006, 1'b0, 32'h0000_0000, 32'h0000_0006};
    vecs[1] = '{64'h0000_0000_0000_0006, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[2] = '{64'h0000_0000_0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[3] = '{64'h8000_0000_0000_0000, 1'b1, 32'h8000_0000, 32'h0000_0000};
    vecs[4] = '{64'h0000_0000_0000_0001, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[6] = '{64'h1234_5678_9ABC_DEF0, 1'b1, 32'hEDCB_A987, 32'h6543_2110};
    vecs[7] = '{64'h0000_0001_0000_0000, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};

    // Reset state.
    #12;
    check("rst_ack",   64'(ack_out),   64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count),     64'd0);
    check("rst_hilo",  {out_hi, out_lo}, 64'd0);
    idle_code = dbg_state;
    @(negedge clk); rst = 1'b0;

    // Table-driven captures, one at a time.
    for (int i = 0; i < 8; i++) begin
      push_product(vecs[i].prod, vecs[i].neg);
      @(negedge clk); #1;
      check("vec_hi",    64'(out_hi),    64'(vecs[i].exp_hi));
      check("vec_lo",    64'(out_lo),    64'(vecs[i].exp_lo));
      check("vec_count", 64'(count),     64'd1);
      check("vec_valid", 64'(out_valid), 64'd1);
      pop_one();
    end

    // done_in held high after the ack: exactly one capture.
    @(negedge clk);
    done_in = 1'b1; product_in = 64'd42; neg_in = 1'b0;
    extra_acks = 0;
    begin
      bit got;
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(posedge clk); #1;
        if (ack_out) got = 1;
      end
      check("held_ack_seen", 64'(got), 64'd1);
      if (got) exp_q.push_back(model_entry(64'd42, 1'b0));
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (ack_out) extra_acks++;
    end
    check("held_extra_acks", 64'(extra_acks), 64'd0);
    check("held_count", 64'(count), 64'd1);
    @(negedge clk); done_in = 1'b0;
    @(posedge clk); @(posedge clk);
    drain_all("held_drain");

    // Full backpressure: fill, stall the 5th, free one slot, then retry.
    for (int k = 1; k <= 4; k++) push_product(64'(k), 1'b0);
    @(negedge clk);
    done_in = 1'b1; product_in = 64'd5; neg_in = 1'b0;
    extra_acks = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (ack_out) extra_acks++;
    end
    check("full_no_ack", 64'(extra_acks), 64'd0);
    check("full_count",  64'(count), 64'd4);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    check("full_pop_no_push", 64'(ack_out), 64'd0);
    check("full_pop_count",   64'(count),   64'd3);
    @(negedge clk); out_ready = 1'b0;
    @(posedge clk); #1;
    check("full_retry_ack", 64'(ack_out), 64'd1);
    if (ack_out) exp_q.push_back(model_entry(64'd5, 1'b0));
    @(negedge clk); done_in = 1'b0;
    @(posedge clk); @(posedge clk);
    check("full_order_head", {out_hi, out_lo}, 64'd2);
    drain_all("full_drain");

    // Simultaneous push and pop at count=2.
    push_product(64'd11, 1'b0);
    push_product(64'd12, 1'b0);
    @(negedge clk);
    out_ready = 1'b1; done_in = 1'b1; product_in = 64'd13; neg_in = 1'b0;
    @(posedge clk); #1;
    check("simul_ack",   64'(ack_out), 64'd1);
    check("simul_count", 64'(count),   64'd2);
    if (ack_out) exp_q.push_back(model_entry(64'd13, 1'b0));
    @(negedge clk); out_ready = 1'b0; done_in = 1'b0;
    @(posedge clk); @(posedge clk);
    drain_all("simul_drain");

    // Pointer wrap: ten products through the FIFO, read back in order.
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) push_product(64'(k), 1'b0);
    drain_all("wrap_drain");

`ifdef MULT_OVF_FLAG_EN
    push_product(64'h0000_0000_8000_0000, 1'b0);
    @(negedge clk); #1;
    check("ovf_pos_2p31", 64'(ovf_out), 64'd1);
    pop_one();
    push_product(64'h0000_0000_8000_0000, 1'b1);
    @(negedge clk); #1;
    check("ovf_neg_2p31", 64'(ovf_out), 64'd0);
    pop_one();
`endif

    // Randomized traffic with random consumer stalls.
    rand_done = 0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          logic [63:0] p;
          case ($urandom_range(0, 3))
            0:       p = 64'($urandom_range(0, 7));
            1:       p = {32'd0, $urandom};
            2:       p = 64'h8000_0000_0000_0000 ^ 64'($urandom_range(0, 1));
            default: p = {$urandom, $urandom};
          endcase
          push_product(p, 1'($urandom_range(0, 1)));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 9) < 4);
        end
      end
    join
    drain_all("rand_drain");

    // Async reset with count=3 and the FSM in ACK.
    push_product(64'd21, 1'b0);
    push_product(64'd22, 1'b0);
    @(negedge clk);
    done_in = 1'b1; product_in = 64'd23; neg_in = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_ack",   64'(ack_out), 64'd1);
    check("pre_rst_count", 64'(count),   64'd3);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(count),     64'd0);
    check("arst_ack",   64'(ack_out),   64'd0);
    check("arst_hilo",  {out_hi, out_lo}, 64'd0);
    check("arst_state", 64'(dbg_state), 64'(idle_code));
    @(negedge clk);
    done_in = 1'b0;
    rst = 1'b0;
    push_product(64'd77, 1'b1);
    drain_all("post_rst_drain");

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_result_fifo.md
Name: mult_result_fifo

Overview:
- Downstream stage of the 32x32 shift-add multiplier.
- Captures each finished 64-bit product and applies sign correction: the multiplier works on magnitudes, and a sign tag is supplied with each result.
- Buffers results in a small FIFO and returns the ack that releases the multiplier from DONE.
- Presents results as a valid/ready stream split into HI/LO words for the register-file writeback path.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- done_in  input  1  multiplier is in DONE; product_in is stable.
- product_in  input  64  unsigned magnitude product.
- neg_in  input  1  result sign; 1 = negate. Valid with done_in.
- ack_out  output  1  one-cycle pulse releasing the multiplier.
- out_valid  output  1  head entry is available.
- out_ready  input  1  consumer accepts the head entry.
- out_hi  output  32  head entry bits [63:32].
- out_lo  output  32  head entry bits [31:0].
- count  output  AW+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Reset (asynchronous, immediate):
  - ack_out=0, out_valid=0, count=0, out_hi=0, out_lo=0.
  - Pointers cleared, FSM to IDLE, storage contents don't-care.
- Capture FSM states: IDLE, ACK, RELEASE.
  - IDLE: on a clock edge with done_in=1 and count<DEPTH:
    - write entry = neg_in ? (~product_in + 1) mod 2^64 : product_in;
    - go to ACK.
  - IDLE with done_in=1 and count==DEPTH (full): no write, stay IDLE, ack_out stays 0. The multiplier is held in DONE (backpressure).
  - ACK: ack_out=1 for exactly this one cycle, then go to RELEASE.
  - RELEASE: ack_out=0. Wait for done_in=0, then go to IDLE. This guarantees one capture per product even if done_in stays high across the ack edge.
- ack_out is a registered FSM decode. It is high the cycle after the capture edge.
- Negation:
  - Full 64-bit two's complement.
  - Negating 0 gives 0.
  - Negating 2^63 gives 2^63 (wrap, no flag).
- FIFO:
  - Push is the capture write. Pop is out_valid && out_ready at a clock edge.
  - Pointers wrap modulo DEPTH.
  - count is +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Full decision uses count before the edge. With count==DEPTH and pop in the same cycle, only the pop happens; the push is retried next cycle, since the FSM is still in IDLE.
  - Empty with push: out_valid rises after the push edge. There is no combinational fall-through; latency is 1 cycle from capture edge to out_valid.
  - out_valid = (count != 0). out_hi/out_lo show the head entry and change only after a pop or after a push into an empty FIFO.
  - out_ready while out_valid=0 is ignored.
- Reset mid-operation: all state is discarded, including buffered entries and a pending ACK. The multiplier must be reset in the same cycle.

Optional Feature:
- Macro MULT_OVF_FLAG_EN.
- Defined:
  - Adds output port ovf_out (1 bit), stored per entry alongside the data.
  - ovf is set when the corrected 64-bit result does not fit a signed 32-bit value, i.e. bits [63:31] are not all equal.
  - ovf_out is valid with out_valid and resets to 0.
- Undefined: no port, no extra storage, behaviour otherwise identical.

Test Plan:
- Basic capture: done_in=1, product_in=64'h0000_0000_0000_0006, neg_in=0 → ack_out pulses 1 cycle later. After the capture edge: out_valid=1, out_hi=0, out_lo=6, count=1.
- Negate: product_in=6, neg_in=1 → out_hi=32'hFFFF_FFFF, out_lo=32'hFFFF_FFFA. Also product_in=0, neg_in=1 → out_hi=0, out_lo=0.
- Held done: done_in held high for 5 cycles after ack → exactly one entry captured, count=1, one ack pulse total.
- Full backpressure: DEPTH=4, out_ready=0, push 4 products (1,2,3,4). A 5th done_in with product 5 → no ack, count=4. Raise out_ready for 1 cycle → pop value 1; next cycle capture 5 and pulse ack. Drain order must be 2,3,4,5.
- Simultaneous push/pop at count=2 → count stays 2, order preserved. Pointer wrap verified by 10 sequential products 1..10 read back in order.
- Async reset with count=3 and the FSM in ACK → out_valid=0, count=0, ack_out=0 immediately, without waiting for a clock edge. With MULT_OVF_FLAG_EN: product 2^31, neg_in=0 → ovf_out=1; product 2^31, neg_in=1 → ovf_out=0.
